// File: rtl/bus_cycle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_cycle_gen : 8086-style multiplexed bus master (T1..T4 with TW waits).   |
// | Optional wait-state abort enabled by defining BUS_TIMEOUT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_cycle_gen #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     req_wr,
  input  logic                     req_io,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     busy,
  output logic                     ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     timeout_err,
  output logic                     ALE,
  output logic                     rdb,
  output logic                     wrb,
  output logic                     IOM,
  output logic [DATA_W-1:0]        ad_out,
  output logic                     ad_oe,
  input  logic [DATA_W-1:0]        ad_in,
  output logic [ADDR_W-DATA_W-1:0] a_hi,
  input  logic                     ready
);

  localparam int c_HI_W = ADDR_W - DATA_W;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_T1   = 6'b000010,
    S_T2   = 6'b000100,
    S_T3   = 6'b001000,
    S_TW   = 6'b010000,
    S_T4   = 6'b100000
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_wr;
  logic               r_io;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_start;
  logic               w_strobe;
  logic               w_done;
  logic               w_timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign w_start  = (r_state == S_IDLE) && req;
  assign w_strobe = (r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW);
  assign w_done   = ((r_state == S_T3) || (r_state == S_TW)) && ready;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] c_TW_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tw_cnt;
  logic       r_timeout_err;

  // Counter is zeroed while in T2 so it reads 0 on the first TW cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tw_cnt      <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_T2)
        r_tw_cnt <= 8'd0;
      else if ((r_state == S_TW) && !ready)
        r_tw_cnt <= r_tw_cnt + 8'd1;
      if (w_start)
        r_timeout_err <= 1'b0;
      else if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout   = (r_state == S_TW) && !ready && (r_tw_cnt == c_TW_LAST);
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req) w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = ready ? S_T4 : S_TW;
      S_TW:    w_next = (ready || w_timeout) ? S_T4 : S_TW;
      S_T4:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_wr    <= req_wr;
        r_io    <= req_io;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_done && !r_wr)
        r_rdata <= ad_in;
      else if (w_timeout && !r_wr)
        r_rdata <= '1;
    end
  end

  // Bus outputs decode from the state register and the latched request only.
  always_comb begin
    busy   = (r_state != S_IDLE);
    ack    = (r_state == S_T4);
    ALE    = (r_state == S_T1);
    rdb    = !(w_strobe && !r_wr);
    wrb    = !(w_strobe && r_wr);
    ad_oe  = (r_state == S_T1) || (w_strobe && r_wr);
    ad_out = '0;
    IOM    = 1'b0;
    a_hi   = '0;
    if (r_state == S_T1)
      ad_out = r_addr[DATA_W-1:0];
    else if (w_strobe && r_wr)
      ad_out = r_wdata;
    if (r_state != S_IDLE) begin
      IOM  = r_io;
      a_hi = r_addr[ADDR_W-1 -: c_HI_W];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire
